// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Dynamic branch predictor: a table of saturating counters indexed either by
//   the PC (bimodal, MODE=0) or by the PC XOR a global history register
//   (gshare, MODE=1). The lookup is combinational for Fetch. Training happens
//   on branches resolved in Execute. The block also flags mispredicts and keeps
//   saturating branch/mispredict statistics.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   lookup_valid/pc     Fetch lookup request
//   predict_taken       guess for lookup_pc (0 when lookup_valid=0)
//   predict_index       table index used for lookup_pc (tracks PC/GHR always)
//   update_valid/index  resolved conditional branch and the index it was predicted with
//   update_taken        actual outcome
//   update_predicted    guess that was carried with the branch
//   mispredict          registered, one cycle after a wrong guess
//   stat_branches       saturating count of resolved branches
//   stat_mispredicts    saturating count of mispredicts
module gshare_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned HIST_BITS  = 6,
    parameter int unsigned MODE       = 1,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_pc,
    output logic                  predict_taken,
    output logic [INDEX_BITS-1:0] predict_index,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic                  update_predicted,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;
    // A zero-length history still needs a legal vector; it is never used for indexing.
    localparam int unsigned GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    logic [CTR_WIDTH-1:0]  ctr_q [DEPTH];
    logic [CTR_WIDTH-1:0]  ctr_d [DEPTH];
    logic [GHR_W-1:0]      ghr_q, ghr_d;
    logic                  mispredict_q, mispredict_d;
    logic [STAT_WIDTH-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_WIDTH-1:0] stat_mispredicts_q, stat_mispredicts_d;

    logic [INDEX_BITS-1:0] pc_idx;
    logic [INDEX_BITS-1:0] hist_idx;
    logic [CTR_WIDTH-1:0]  sel_ctr;
    logic [CTR_WIDTH-1:0]  upd_ctr;

    // Lookup: reads registered state only, so a same-cycle update is not visible yet.
    always_comb begin
        pc_idx   = lookup_pc[INDEX_BITS+1:2];
        hist_idx = '0;
        if (MODE == 1 && HIST_BITS > 0) begin
            hist_idx = INDEX_BITS'(ghr_q);
        end
        predict_index = pc_idx ^ hist_idx;
        sel_ctr       = ctr_q[predict_index];
        predict_taken = lookup_valid & sel_ctr[CTR_WIDTH-1];
    end

    // Training, history shift, mispredict flag and statistics.
    always_comb begin
        ctr_d              = ctr_q;
        ghr_d              = ghr_q;
        upd_ctr            = ctr_q[update_index];
        mispredict_d       = update_valid & (update_taken ^ update_predicted);
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (update_valid) begin
            if (update_taken) begin
                if (upd_ctr != '1) begin
                    ctr_d[update_index] = upd_ctr + CTR_WIDTH'(1);
                end
            end else if (upd_ctr != '0) begin
                ctr_d[update_index] = upd_ctr - CTR_WIDTH'(1);
            end
            // Truncating {ghr, taken} keeps the newest GHR_W bits, oldest bit drops out.
            ghr_d = GHR_W'({ghr_q, update_taken});
            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + STAT_WIDTH'(1);
            end
        end
        if (mispredict_d && stat_mispredicts_q != '1) begin
            stat_mispredicts_d = stat_mispredicts_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_q[i[INDEX_BITS-1:0]] <= CTR_INIT;
            end
            ghr_q              <= '0;
            mispredict_q       <= 1'b0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_q[i[INDEX_BITS-1:0]] <= ctr_d[i[INDEX_BITS-1:0]];
            end
            ghr_q              <= ghr_d;
            mispredict_q       <= mispredict_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

    // Word-aligned PC: low bits and bits above the index are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0], ghr_q};

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor: a bimodal instance (32-bit stats) and a
// gshare instance (4-bit stats) share the same stimulus. A driver issues
// directed and random cycles and pushes the expected outputs of an integer
// reference model; a monitor pops and compares on the falling edge.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [5:0]  update_index;
    logic        update_taken;
    logic        update_predicted;

    logic        pt0, pt1, mi0, mi1;
    logic [5:0]  ix0, ix1;
    logic [31:0] br0, mp0;
    logic [3:0]  br1, mp1;

    always #5 clk = ~clk;

    gshare_predictor #(.INDEX_BITS(6), .CTR_WIDTH(2), .HIST_BITS(6), .MODE(0), .STAT_WIDTH(32)) u_bim (
        .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_taken(pt0), .predict_index(ix0), .update_valid(update_valid),
        .update_index(update_index), .update_taken(update_taken),
        .update_predicted(update_predicted), .mispredict(mi0),
        .stat_branches(br0), .stat_mispredicts(mp0)
    );

    gshare_predictor #(.INDEX_BITS(6), .CTR_WIDTH(2), .HIST_BITS(6), .MODE(1), .STAT_WIDTH(4)) u_gsh (
        .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_taken(pt1), .predict_index(ix1), .update_valid(update_valid),
        .update_index(update_index), .update_taken(update_taken),
        .update_predicted(update_predicted), .mispredict(mi1),
        .stat_branches(br1), .stat_mispredicts(mp1)
    );

    typedef struct packed {
        bit        known;
        bit        pt0, pt1;
        bit [5:0]  ix0, ix1;
        bit        mi0, mi1;
        bit [31:0] br0, mp0;
        bit [3:0]  br1, mp1;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: plain integers per instance (0 = bimodal, 1 = gshare).
    int          ctr [2][64];
    int unsigned ghr [2];
    int unsigned nbr [2];
    int unsigned nmp [2];
    bit          mis [2];
    bit          known = 0;

    // Inputs currently applied (what the DUT sees at the next rising edge).
    bit          c_rst, c_lv, c_uv, c_ut, c_up;
    int unsigned c_pc, c_ui;

    function automatic int unsigned stat_max(int d);
        return (d == 0) ? 32'hFFFF_FFFF : 15;
    endfunction

    function automatic int unsigned m_idx(int d);
        int unsigned base = (c_pc / 4) % 64;
        return (d == 1) ? (base ^ ghr[1]) : base;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (c_rst) begin
                for (int i = 0; i < 64; i++) ctr[d][i] = 1;
                ghr[d] = 0; nbr[d] = 0; nmp[d] = 0; mis[d] = 0;
            end else begin
                mis[d] = c_uv && (c_ut != c_up);
                if (c_uv) begin
                    if (c_ut) ctr[d][c_ui] = (ctr[d][c_ui] < 3) ? ctr[d][c_ui] + 1 : 3;
                    else      ctr[d][c_ui] = (ctr[d][c_ui] > 0) ? ctr[d][c_ui] - 1 : 0;
                    ghr[d] = (ghr[d] * 2 + (c_ut ? 1 : 0)) % 64;
                    if (nbr[d] < stat_max(d)) nbr[d]++;
                end
                if (mis[d] && nmp[d] < stat_max(d)) nmp[d]++;
            end
        end
        if (c_rst) known = 1;
    endtask

    task automatic drive(input bit rst, input bit lv, input int unsigned pc, input bit uv,
                         input int unsigned ui, input bit ut, input bit up);
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        c_rst = rst; c_lv = lv; c_pc = pc; c_uv = uv; c_ui = ui % 64; c_ut = ut; c_up = up;
        reset = rst; lookup_valid = lv; lookup_pc = pc; update_valid = uv;
        update_index = 6'(c_ui); update_taken = ut; update_predicted = up;
        e.known = known;
        e.ix0 = 6'(m_idx(0));
        e.ix1 = 6'(m_idx(1));
        e.pt0 = lv && (ctr[0][m_idx(0)] >= 2);
        e.pt1 = lv && (ctr[1][m_idx(1)] >= 2);
        e.mi0 = mis[0]; e.mi1 = mis[1];
        e.br0 = nbr[0]; e.mp0 = nmp[0];
        e.br1 = 4'(nbr[1]); e.mp1 = 4'(nmp[1]);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.known) begin
                    chk("bim_predict_taken", pt0, e.pt0);
                    chk("bim_predict_index", ix0, e.ix0);
                    chk("bim_mispredict", mi0, e.mi0);
                    chk("bim_stat_branches", br0, e.br0);
                    chk("bim_stat_mispredicts", mp0, e.mp0);
                    chk("gsh_predict_taken", pt1, e.pt1);
                    chk("gsh_predict_index", ix1, e.ix1);
                    chk("gsh_mispredict", mi1, e.mi1);
                    chk("gsh_stat_branches", br1, e.br1);
                    chk("gsh_stat_mispredicts", mp1, e.mp1);
                end
            end
        end
    end

    initial begin : driver
        c_rst = 1; c_lv = 0; c_pc = 0; c_uv = 0; c_ui = 0; c_ut = 0; c_up = 0;
        reset = 1; lookup_valid = 0; lookup_pc = '0; update_valid = 0;
        update_index = '0; update_taken = 0; update_predicted = 0;

        // Basic lookup and single taken update on index 0x10 (PC 0x40).
        drive(0, 1, 32'h40, 0, 0, 0, 0);
        drive(0, 0, 32'h40, 1, 6'h10, 1, 1);
        drive(0, 1, 32'h40, 0, 0, 0, 0);
        drive(0, 1, 32'h44, 0, 0, 0, 0);

        // Saturation on index 5 (PC 0x14).
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 32'h14, 1, 5, 1, 1);
        drive(0, 1, 32'h14, 1, 5, 0, 1);
        drive(0, 1, 32'h14, 1, 5, 0, 1);
        drive(0, 1, 32'h14, 0, 0, 0, 0);

        // Mispredict pulse and counters.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 9, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // History T,T,N then lookup PC 0x100.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 1, 1);
        drive(0, 0, 0, 1, 2, 1, 1);
        drive(0, 0, 0, 1, 3, 0, 0);
        drive(0, 1, 32'h100, 0, 0, 0, 0);

        // Same-cycle lookup and update of index 3 (read before write).
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0C, 1, 3, 1, 0);
        drive(0, 1, 32'h0C, 0, 0, 0, 0);

        // Statistics saturation, then mid-run reset with a concurrent update.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) drive(0, 1, 32'h20, 1, 8, 1, i[0]);
        drive(1, 1, 32'h20, 1, 8, 1, 0);
        drive(0, 1, 32'h20, 0, 0, 0, 0);
        drive(0, 1, 32'h20, 0, 0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 9) < 7), $urandom_range(0, 63),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
